// File: rtl/inst_buffer_pkg.sv
// sys_defs: shared definitions for the instruction buffer slice.
//   `IB_SIZE   : default buffer depth (entry count, power of two, >= 4)
//   PC_W       : program counter width
//   IB_PTR     : pointer type sized for `IB_SIZE entries
//   IBEntry_t  : one buffered instruction with its prediction metadata
//   popcount2  : number of set bits in a 2-bit lane vector
// Optional feature elsewhere in the slice: IB_BYPASS_EN (see inst_buffer.sv).
`ifndef IB_SIZE
`define IB_SIZE 8
`endif

package sys_defs;

  localparam int PC_W     = 32;
  localparam int IB_PTR_W = $clog2(`IB_SIZE);

  typedef logic [IB_PTR_W-1:0] IB_PTR;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pred_NPC;
    logic [PC_W-1:0] not_taken_NPC;
    logic            pred_taken;
  } IBEntry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/inst_buffer_wrap_ptr.sv
// ib_wrap_ptr: circular pointer register for the instruction buffer.
// Advances by 0, 1 or 2 each cycle and wraps modulo SIZE, which works out
// naturally because SIZE is a power of two and the register is log2(SIZE) wide.
// Ports:
//   clk, reset : clock and synchronous active-high reset (pointer -> 0)
//   clear_i    : synchronous clear (pointer -> 0), used on flush
//   inc_i      : increment amount, 0..2
//   ptr_o      : current pointer value
module ib_wrap_ptr #(
  parameter int SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic [1:0]              inc_i,
  output logic [$clog2(SIZE)-1:0] ptr_o
);

  localparam int PW = $clog2(SIZE);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q + PW'(inc_i);
    if (clear_i) ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: two-wide circular instruction buffer between fetch/branch
// prediction and dispatch. Lane 0 is always the older instruction.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   if_inst/if_fetch_valid/bp_* : up to two fetched instructions + metadata
//   br_mispredict      : flushes the whole buffer
//   dis_take           : dispatch consumption, thermometer 00/01/11
//   if_valid           : per-lane acceptance, back to fetch and the predictor
//   ib_*               : head and head+1 entries, ib_valid marks valid lanes
//   ib_count           : registered occupancy
// Macro IB_BYPASS_EN: when defined, an empty buffer forwards accepted
// incoming lanes to the outputs in the same cycle; otherwise the path is
// strictly registered.
module inst_buffer
  import sys_defs::*;
#(
  parameter int SIZE = `IB_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0][31:0]        if_inst,
  input  logic [1:0]              if_fetch_valid,
  input  logic [1:0][PC_W-1:0]    bp_pred_NPC,
  input  logic [1:0][PC_W-1:0]    bp_not_taken_NPC,
  input  logic [1:0]              bp_pred_taken,
  input  logic                    br_mispredict,
  input  logic [1:0]              dis_take,
  output logic [1:0]              if_valid,
  output logic [1:0][31:0]        ib_inst,
  output logic [1:0][PC_W-1:0]    ib_pred_NPC,
  output logic [1:0][PC_W-1:0]    ib_not_taken_NPC,
  output logic [1:0]              ib_pred_taken,
  output logic [1:0]              ib_valid,
  output logic [$clog2(SIZE):0]   ib_count
);

  localparam int PW = $clog2(SIZE);
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;

  IBEntry_t      entries_q [SIZE];
  logic [CW-1:0] count_q, count_d;
  ptr_t          head, tail, headNext;
  ptr_t          wrIdx [2];
  logic          flush, bypassActive, acc0;
  logic [CW-1:0] freeSlots;
  logic [1:0]    pushCnt, takeCnt, skipCnt;
  logic [1:0]    wrEn;
  IBEntry_t      laneEntry [2];
  IBEntry_t      inEntry [2];
  IBEntry_t      outEntry [2];

  // Acceptance only looks at registered occupancy, so space freed by this
  // cycle's dispatch is not reused until next cycle and if_valid never
  // depends on dis_take.
  always_comb begin
    flush     = reset | br_mispredict;
    freeSlots = CW'(SIZE) - count_q;
    acc0      = if_fetch_valid[0] && !flush && (freeSlots >= CW'(1));
    if_valid[0] = acc0;
    if_valid[1] = if_fetch_valid[1] && !flush &&
                  (freeSlots >= (CW'(1) + CW'(acc0)));
    pushCnt = popcount2(if_valid);
    takeCnt = popcount2(dis_take);
  end

  // Incoming lanes are compacted so that the oldest accepted instruction
  // always lands at tail; if only lane 1 is accepted it moves to slot 0.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      laneEntry[k].inst          = if_inst[k];
      laneEntry[k].pred_NPC      = bp_pred_NPC[k];
      laneEntry[k].not_taken_NPC = bp_not_taken_NPC[k];
      laneEntry[k].pred_taken    = bp_pred_taken[k];
    end
    inEntry[0] = if_valid[0] ? laneEntry[0] : laneEntry[1];
    inEntry[1] = laneEntry[1];
  end

  // Bypass is only possible from an empty, non-flushing buffer. Entries that
  // dispatch takes straight off the bypass are skipped on write; since
  // head == tail when empty, the untaken ones still sit at tail + k.
  always_comb begin
`ifdef IB_BYPASS_EN
    bypassActive = (count_q == '0) && !flush;
`else
    bypassActive = 1'b0;
`endif
    skipCnt = bypassActive ? takeCnt : 2'd0;
    for (int k = 0; k < 2; k++) begin
      wrEn[k]  = !flush && (2'(k) < pushCnt) && (2'(k) >= skipCnt);
      wrIdx[k] = tail + ptr_t'(k);
    end
  end

  // Occupancy: a flush zeroes it; otherwise push and pop combine freely.
  always_comb begin
    count_d = count_q + CW'(pushCnt) - CW'(takeCnt);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Entry storage: cleared on reset only; a mispredict just drops the writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) entries_q[i] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wrEn[k]) entries_q[wrIdx[k]] <= inEntry[k];
      end
    end
  end

  ib_wrap_ptr #(.SIZE(SIZE)) u_head (
    .clk    (clk),
    .reset  (reset),
    .clear_i(br_mispredict),
    .inc_i  (flush ? 2'd0 : takeCnt),
    .ptr_o  (head)
  );

  ib_wrap_ptr #(.SIZE(SIZE)) u_tail (
    .clk    (clk),
    .reset  (reset),
    .clear_i(br_mispredict),
    .inc_i  (flush ? 2'd0 : pushCnt),
    .ptr_o  (tail)
  );

  // Dispatch view: head and head+1, or the compacted incoming lanes when
  // bypassing. Everything reads as zero while reset is held.
  always_comb begin
    headNext    = head + ptr_t'(1);
    outEntry[0] = entries_q[head];
    outEntry[1] = entries_q[headNext];
    ib_valid    = {count_q >= CW'(2), count_q >= CW'(1)};
    if (bypassActive) begin
      outEntry[0] = inEntry[0];
      outEntry[1] = inEntry[1];
      ib_valid    = {pushCnt == 2'd2, pushCnt != 2'd0};
    end
    if (reset) begin
      outEntry[0] = '0;
      outEntry[1] = '0;
      ib_valid    = 2'b00;
    end
    for (int k = 0; k < 2; k++) begin
      ib_inst[k]          = outEntry[k].inst;
      ib_pred_NPC[k]      = outEntry[k].pred_NPC;
      ib_not_taken_NPC[k] = outEntry[k].not_taken_NPC;
      ib_pred_taken[k]    = outEntry[k].pred_taken;
    end
  end

  assign ib_count = count_q;

  // Dispatch must use a thermometer code and never take more than offered.
  always_ff @(posedge clk) begin
    if (!flush) begin
      assert (dis_take != 2'b10)
        else $error("inst_buffer: dis_take = 10 is not a thermometer code");
      assert (takeCnt <= popcount2(ib_valid))
        else $error("inst_buffer: dis_take exceeds ib_valid");
    end
  end

endmodule
